riscv_ex_pipe: RTL and testbench

RISCV_EX_PIPE -- requirements
Module: riscv_ex_pipe

---
 rtl/riscv_ex_pipe.sv | 230 +++++++++++++++++++++++
 tb/tb_riscv_ex_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_ex_pipe.sv
`default_nettype none
// ============================================================================
// Module   : riscv_ex_pipe
// Purpose  : RV32 execute stage bracketed by the ID/EX and EX/MEM pipeline
//            registers. It contains operand forwarding, the ALU, the branch
//            compare and the branch/jump redirect.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            stall_i, flush_i     - per-stage controls, bits [2]=ID/EX, [3]=EX/MEM
//            pc_i .. wb_mem_sel_i - decoded instruction from ID
//            memwb_*_i            - MEM/WB writeback, used for forwarding
//            br_addr_o, br_jmp_en_o - redirect target and enable (EX stage)
//            exmem_*_o            - EX/MEM register contents
// Config   : FORWARDING_EN - when defined, EX/MEM and MEM/WB results are
//            forwarded to the ALU/branch operands; otherwise the operands
//            come straight from the register file data.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_ex_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  stall_i,
    input  logic [4:0]  flush_i,
    input  logic [31:0] pc_i,
    input  logic [4:0]  r1_i,
    input  logic [4:0]  r2_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] d1_i,
    input  logic [31:0] d2_i,
    input  logic [31:0] imm_i,
    input  logic [2:0]  ex_f3_i,
    input  logic [6:0]  ex_f7_i,
    input  logic        ex_imm_sel_i,
    input  logic        ex_pc_sel_i,
    input  logic        ex_jmp_i,
    input  logic        ex_br_i,
    input  logic        mem_re_i,
    input  logic        mem_wr_i,
    input  logic [2:0]  mem_f3_i,
    input  logic        wb_reg_wr_i,
    input  logic        wb_mem_sel_i,
    input  logic [4:0]  memwb_rd_i,
    input  logic [31:0] memwb_wdata_i,
    input  logic        memwb_wb_reg_wr_i,
    output logic [31:0] br_addr_o,
    output logic        br_jmp_en_o,
    output logic [4:0]  exmem_rd_o,
    output logic [31:0] exmem_alu_o,
    output logic [31:0] exmem_wdata_o,
    output logic        exmem_mem_re_o,
    output logic        exmem_mem_wr_o,
    output logic        exmem_wb_reg_wr_o,
    output logic        exmem_wb_mem_sel_o,
    output logic [2:0]  exmem_mem_f3_o
);

    localparam logic [31:0] c_PC_STEP = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        imm_sel;
        logic        pc_sel;
        logic        jmp;
        logic        br;
        logic        mem_re;
        logic        mem_wr;
        logic [2:0]  mem_f3;
        logic        wb_reg_wr;
        logic        wb_mem_sel;
    } idex_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic        mem_re;
        logic        mem_wr;
        logic        wb_reg_wr;
        logic        wb_mem_sel;
        logic [2:0]  mem_f3;
    } exmem_t;

    idex_t       r_idex;
    idex_t       w_idex_in;
    exmem_t      r_exmem;
    exmem_t      w_exmem_in;

    logic [31:0] w_fwd_rs1;
    logic [31:0] w_fwd_rs2;
    logic [31:0] w_op_a;
    logic [31:0] w_op_b;
    logic [4:0]  w_shamt;
    logic [31:0] w_sum;
    logic        w_force_add;
    logic [31:0] w_alu;
    logic        w_taken;
    logic [31:0] w_ex_result;

    assign w_idex_in = '{pc: pc_i, r1: r1_i, r2: r2_i, rd: rd_i,
                         d1: d1_i, d2: d2_i, imm: imm_i,
                         f3: ex_f3_i, f7: ex_f7_i,
                         imm_sel: ex_imm_sel_i, pc_sel: ex_pc_sel_i,
                         jmp: ex_jmp_i, br: ex_br_i,
                         mem_re: mem_re_i, mem_wr: mem_wr_i, mem_f3: mem_f3_i,
                         wb_reg_wr: wb_reg_wr_i, wb_mem_sel: wb_mem_sel_i};

    // ID/EX: flush beats stall so a squashed instruction cannot linger.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idex <= '0;
        end else if (flush_i[2]) begin
            r_idex <= '0;
        end else if (!stall_i[2]) begin
            r_idex <= w_idex_in;
        end
    end

    // Operand forwarding: the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        w_fwd_rs1 = r_idex.d1;
        w_fwd_rs2 = r_idex.d2;
`ifdef FORWARDING_EN
        if (r_exmem.wb_reg_wr && (r_exmem.rd == r_idex.r1) && (r_idex.r1 != 5'd0)) begin
            w_fwd_rs1 = r_exmem.alu;
        end else if (memwb_wb_reg_wr_i && (memwb_rd_i == r_idex.r1) && (r_idex.r1 != 5'd0)) begin
            w_fwd_rs1 = memwb_wdata_i;
        end
        if (r_exmem.wb_reg_wr && (r_exmem.rd == r_idex.r2) && (r_idex.r2 != 5'd0)) begin
            w_fwd_rs2 = r_exmem.alu;
        end else if (memwb_wb_reg_wr_i && (memwb_rd_i == r_idex.r2) && (r_idex.r2 != 5'd0)) begin
            w_fwd_rs2 = memwb_wdata_i;
        end
`endif
    end

`ifndef FORWARDING_EN
    // Forwarding sources have no consumer in this build.
    logic w_unused_fwd;
    assign w_unused_fwd = ^{memwb_rd_i, memwb_wdata_i, memwb_wb_reg_wr_i, r_idex.r1, r_idex.r2};
`endif

    // Stage controls for other pipeline stages and non-decoding funct7 bits.
    logic w_unused_ctrl;
    assign w_unused_ctrl = ^{stall_i[4], stall_i[1:0], flush_i[4:3], flush_i[1:0],
                             r_idex.f7[6], r_idex.f7[4:0]};

    assign w_op_a      = r_idex.pc_sel  ? r_idex.pc  : w_fwd_rs1;
    assign w_op_b      = r_idex.imm_sel ? r_idex.imm : w_fwd_rs2;
    assign w_shamt     = w_op_b[4:0];
    assign w_sum       = w_op_a + w_op_b;
    // Address generation for jumps, branches and memory always needs ADD,
    // whatever funct3 happens to hold for those encodings.
    assign w_force_add = r_idex.jmp | r_idex.br | r_idex.mem_re | r_idex.mem_wr;

    always_comb begin
        w_alu = w_sum;
        case (r_idex.f3)
            3'b000: w_alu = (r_idex.f7[5] && !r_idex.imm_sel) ? (w_op_a - w_op_b) : w_sum;
            3'b001: w_alu = w_op_a << w_shamt;
            3'b010: w_alu = {31'd0, $signed(w_op_a) < $signed(w_op_b)};
            3'b011: w_alu = {31'd0, w_op_a < w_op_b};
            3'b100: w_alu = w_op_a ^ w_op_b;
            3'b101: w_alu = r_idex.f7[5] ? $unsigned($signed(w_op_a) >>> w_shamt)
                                         : (w_op_a >> w_shamt);
            3'b110: w_alu = w_op_a | w_op_b;
            3'b111: w_alu = w_op_a & w_op_b;
            default: w_alu = w_sum;
        endcase
        if (w_force_add) begin
            w_alu = w_sum;
        end
    end

    always_comb begin
        w_taken = 1'b0;
        case (r_idex.f3)
            3'b000: w_taken = (w_fwd_rs1 == w_fwd_rs2);
            3'b001: w_taken = (w_fwd_rs1 != w_fwd_rs2);
            3'b100: w_taken = ($signed(w_fwd_rs1) <  $signed(w_fwd_rs2));
            3'b101: w_taken = ($signed(w_fwd_rs1) >= $signed(w_fwd_rs2));
            3'b110: w_taken = (w_fwd_rs1 <  w_fwd_rs2);
            3'b111: w_taken = (w_fwd_rs1 >= w_fwd_rs2);
            default: w_taken = 1'b0;
        endcase
    end

    // JALR (register-relative jump) target has bit 0 cleared.
    assign br_addr_o   = {w_sum[31:1], w_sum[0] & ~(r_idex.jmp & ~r_idex.pc_sel)};
    assign br_jmp_en_o = r_idex.jmp | (r_idex.br & w_taken);

    // Jumps write back the link address.
    assign w_ex_result = r_idex.jmp ? (r_idex.pc + c_PC_STEP) : w_alu;

    assign w_exmem_in = '{rd: r_idex.rd, alu: w_ex_result, wdata: w_fwd_rs2,
                          mem_re: r_idex.mem_re, mem_wr: r_idex.mem_wr,
                          wb_reg_wr: r_idex.wb_reg_wr, wb_mem_sel: r_idex.wb_mem_sel,
                          mem_f3: r_idex.mem_f3};

    // EX/MEM: when only ID/EX is stalled, the instruction stays in EX and
    // will be re-executed, so a bubble goes downstream in its place.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exmem <= '0;
        end else if (stall_i[3]) begin
            r_exmem <= r_exmem;
        end else if (stall_i[2]) begin
            r_exmem <= '0;
        end else begin
            r_exmem <= w_exmem_in;
        end
    end

    assign exmem_rd_o         = r_exmem.rd;
    assign exmem_alu_o        = r_exmem.alu;
    assign exmem_wdata_o      = r_exmem.wdata;
    assign exmem_mem_re_o     = r_exmem.mem_re;
    assign exmem_mem_wr_o     = r_exmem.mem_wr;
    assign exmem_wb_reg_wr_o  = r_exmem.wb_reg_wr;
    assign exmem_wb_mem_sel_o = r_exmem.wb_mem_sel;
    assign exmem_mem_f3_o     = r_exmem.mem_f3;

endmodule
`default_nettype wire

// File: tb/tb_riscv_ex_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_ex_pipe
// Purpose  : Directed scoreboard bench for riscv_ex_pipe. Each issued
//            instruction is evaluated by an instruction-level model; the
//            EX/MEM record is queued with the cycle it should appear and the
//            redirect outputs are compared one edge after issue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_ex_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  stall_i, flush_i;
    logic [31:0] pc_i, d1_i, d2_i, imm_i;
    logic [4:0]  r1_i, r2_i, rd_i;
    logic [2:0]  ex_f3_i, mem_f3_i;
    logic [6:0]  ex_f7_i;
    logic        ex_imm_sel_i, ex_pc_sel_i, ex_jmp_i, ex_br_i;
    logic        mem_re_i, mem_wr_i, wb_reg_wr_i, wb_mem_sel_i;
    logic [4:0]  memwb_rd_i;
    logic [31:0] memwb_wdata_i;
    logic        memwb_wb_reg_wr_i;
    logic [31:0] br_addr_o;
    logic        br_jmp_en_o;
    logic [4:0]  exmem_rd_o;
    logic [31:0] exmem_alu_o, exmem_wdata_o;
    logic        exmem_mem_re_o, exmem_mem_wr_o, exmem_wb_reg_wr_o, exmem_wb_mem_sel_o;
    logic [2:0]  exmem_mem_f3_o;

    riscv_ex_pipe dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .pc_i(pc_i), .r1_i(r1_i), .r2_i(r2_i), .rd_i(rd_i),
        .d1_i(d1_i), .d2_i(d2_i), .imm_i(imm_i),
        .ex_f3_i(ex_f3_i), .ex_f7_i(ex_f7_i),
        .ex_imm_sel_i(ex_imm_sel_i), .ex_pc_sel_i(ex_pc_sel_i),
        .ex_jmp_i(ex_jmp_i), .ex_br_i(ex_br_i),
        .mem_re_i(mem_re_i), .mem_wr_i(mem_wr_i), .mem_f3_i(mem_f3_i),
        .wb_reg_wr_i(wb_reg_wr_i), .wb_mem_sel_i(wb_mem_sel_i),
        .memwb_rd_i(memwb_rd_i), .memwb_wdata_i(memwb_wdata_i),
        .memwb_wb_reg_wr_i(memwb_wb_reg_wr_i),
        .br_addr_o(br_addr_o), .br_jmp_en_o(br_jmp_en_o),
        .exmem_rd_o(exmem_rd_o), .exmem_alu_o(exmem_alu_o), .exmem_wdata_o(exmem_wdata_o),
        .exmem_mem_re_o(exmem_mem_re_o), .exmem_mem_wr_o(exmem_mem_wr_o),
        .exmem_wb_reg_wr_o(exmem_wb_reg_wr_o), .exmem_wb_mem_sel_o(exmem_wb_mem_sel_o),
        .exmem_mem_f3_o(exmem_mem_f3_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic        re;
        logic        wr;
        logic        wre;
        logic        msel;
        logic [2:0]  f3;
    } exm_t;

    exm_t   q_exp[$];
    int     q_due[$];
    string  q_tag[$];
    int     cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    exm_t   last_exp;
    exm_t   saved_exp;
    logic [4:0]  prev_rd = '0;
    logic [31:0] prev_res = '0;
    logic        prev_wre = 1'b0;
    logic [31:0] exp_val;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic exm_t get_obs();
        return exm_t'({exmem_rd_o, exmem_alu_o, exmem_wdata_o, exmem_mem_re_o, exmem_mem_wr_o,
                       exmem_wb_reg_wr_o, exmem_wb_mem_sel_o, exmem_mem_f3_o});
    endfunction

    task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exm_t  e;
        int    d;
        string t;
        @(posedge clk);
        #1;
        cyc++;
        while (q_due.size() != 0 && q_due[0] <= cyc) begin
            e = q_exp.pop_front();
            d = q_due.pop_front();
            t = q_tag.pop_front();
            chk({t, ".exmem"}, get_obs(), e);
        end
    endtask

    function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] d);
        if (r == 5'd0) return d;
`ifdef FORWARDING_EN
        if (prev_wre && prev_rd == r) return prev_res;
        if (memwb_wb_reg_wr_i && memwb_rd_i == r) return memwb_wdata_i;
`endif
        return d;
    endfunction

    function automatic logic [31:0] m_alu(input logic [2:0] f3, input logic f7b5, input logic isel,
                                          input logic fadd, input logic [31:0] a, input logic [31:0] b);
        if (fadd) return a + b;
        case (f3)
            3'd0: return (f7b5 && !isel) ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return f7b5 ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic m_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic clear_in();
        pc_i = '0; r1_i = '0; r2_i = '0; rd_i = '0; d1_i = '0; d2_i = '0; imm_i = '0;
        ex_f3_i = '0; ex_f7_i = '0; ex_imm_sel_i = 0; ex_pc_sel_i = 0; ex_jmp_i = 0; ex_br_i = 0;
        mem_re_i = 0; mem_wr_i = 0; mem_f3_i = '0; wb_reg_wr_i = 0; wb_mem_sel_i = 0;
    endtask

    // Evaluate the driven instruction, optionally queue its EX/MEM record,
    // clock it into EX and compare the redirect outputs.
    task automatic issue(input string tag, input bit do_flush, input bit do_push);
        logic [31:0] a1, b2, opa, opb, sum, res, tgt;
        logic        en;
        a1  = m_fwd(r1_i, d1_i);
        b2  = m_fwd(r2_i, d2_i);
        opa = ex_pc_sel_i ? pc_i : a1;
        opb = ex_imm_sel_i ? imm_i : b2;
        sum = opa + opb;
        res = ex_jmp_i ? pc_i + 32'd4
                       : m_alu(ex_f3_i, ex_f7_i[5], ex_imm_sel_i,
                               ex_jmp_i | ex_br_i | mem_re_i | mem_wr_i, opa, opb);
        tgt = sum;
        if (ex_jmp_i && !ex_pc_sel_i) tgt[0] = 1'b0;
        en  = ex_jmp_i | (ex_br_i & m_taken(ex_f3_i, a1, b2));
        if (do_flush) begin
            last_exp = '0;
            en  = 1'b0;
            tgt = '0;
            flush_i = 5'b00100;
        end else begin
            last_exp = '{rd: rd_i, alu: res, wdata: b2, re: mem_re_i, wr: mem_wr_i,
                         wre: wb_reg_wr_i, msel: wb_mem_sel_i, f3: mem_f3_i};
        end
        prev_rd  = last_exp.rd;
        prev_res = last_exp.alu;
        prev_wre = last_exp.wre;
        if (do_push) begin
            q_exp.push_back(last_exp);
            q_due.push_back(cyc + 2);
            q_tag.push_back(tag);
        end
        tick();
        flush_i = '0;
        chk({tag, ".br_en"}, 76'(br_jmp_en_o), 76'(en));
        chk({tag, ".br_addr"}, 76'(br_addr_o), 76'(tgt));
    endtask

    initial begin
        stall_i = '0; flush_i = '0;
        memwb_rd_i = '0; memwb_wdata_i = '0; memwb_wb_reg_wr_i = 0;
        clear_in();
        // Reset with a live-looking instruction on the inputs.
        pc_i = 32'hDEAD_0000; ex_jmp_i = 1; wb_reg_wr_i = 1; rd_i = 5'd5; d1_i = 32'd1;
        mem_wr_i = 1; stall_i = 5'b01100; flush_i = 5'b00100;
        rst = 1;
        tick();
        chk("reset.exmem", get_obs(), '0);
        chk("reset.br_en", 76'(br_jmp_en_o), 76'd0);
        rst = 0; stall_i = '0; flush_i = '0;
        clear_in();

        // ADDI x1,x0,5 ; ADD x2,x1,x1 back-to-back
        imm_i = 32'd5; ex_imm_sel_i = 1; rd_i = 5'd1; wb_reg_wr_i = 1;
        issue("addi_x1", 0, 1);
        clear_in(); r1_i = 5'd1; r2_i = 5'd1; rd_i = 5'd2; wb_reg_wr_i = 1;
        issue("add_x2", 0, 1);
        clear_in();
        issue("idle0", 0, 1);
`ifdef FORWARDING_EN
        exp_val = 32'd10;
`else
        exp_val = 32'd0;
`endif
        chk("add_x2_value", 76'(exmem_alu_o), 76'(exp_val));

        // EX/MEM versus MEM/WB priority on x3
        memwb_rd_i = 5'd3; memwb_wdata_i = 32'd7; memwb_wb_reg_wr_i = 1;
        clear_in(); imm_i = 32'd9; ex_imm_sel_i = 1; rd_i = 5'd3; wb_reg_wr_i = 1;
        issue("addi_x3", 0, 1);
        clear_in(); r1_i = 5'd3; d1_i = 32'h55; rd_i = 5'd4; wb_reg_wr_i = 1;
        issue("add_x4", 0, 1);
        clear_in(); imm_i = 32'd9; ex_imm_sel_i = 1; rd_i = 5'd0; wb_reg_wr_i = 1;
        issue("addi_x0", 0, 1);
`ifdef FORWARDING_EN
        exp_val = 32'd9;
`else
        exp_val = 32'h55;
`endif
        chk("x3_exmem_prio", 76'(exmem_alu_o), 76'(exp_val));
        clear_in(); r1_i = 5'd3; d1_i = 32'h55; rd_i = 5'd5; wb_reg_wr_i = 1;
        issue("add_x5", 0, 1);
        clear_in();
        issue("idle1", 0, 1);
`ifdef FORWARDING_EN
        exp_val = 32'd7;
`else
        exp_val = 32'h55;
`endif
        chk("x3_memwb_used", 76'(exmem_alu_o), 76'(exp_val));
        memwb_rd_i = '0; memwb_wdata_i = '0; memwb_wb_reg_wr_i = 0;

        // BEQ taken, then flush the wrong-path instruction
        clear_in(); pc_i = 32'h20; imm_i = 32'd8; ex_imm_sel_i = 1; ex_pc_sel_i = 1; ex_br_i = 1;
        r1_i = 5'd6; r2_i = 5'd7; d1_i = 32'h5A; d2_i = 32'h5A;
        issue("beq", 0, 1);
        chk("beq_taken", 76'(br_jmp_en_o), 76'd1);
        chk("beq_target", 76'(br_addr_o), 76'h28);
        clear_in(); imm_i = 32'd1; ex_imm_sel_i = 1; rd_i = 5'd9; wb_reg_wr_i = 1; pc_i = 32'h24;
        issue("wrong_path", 1, 1);
        clear_in();
        issue("idle2", 0, 1);
        chk("flush_bubble", get_obs(), '0);

        // JALR x1, 4(x8)
        clear_in(); pc_i = 32'h40; r1_i = 5'd8; d1_i = 32'h101; imm_i = 32'd4; ex_imm_sel_i = 1;
        ex_jmp_i = 1; rd_i = 5'd1; wb_reg_wr_i = 1;
        issue("jalr", 0, 1);
        chk("jalr_target", 76'(br_addr_o), 76'h104);
        chk("jalr_redirect", 76'(br_jmp_en_o), 76'd1);
        clear_in();
        issue("idle3", 0, 1);
        chk("jalr_link", 76'(exmem_alu_o), 76'h44);

        // SUB 3-5 and SRAI 0x80000000 >> 4
        clear_in(); r1_i = 5'd10; r2_i = 5'd11; d1_i = 32'd3; d2_i = 32'd5; ex_f7_i = 7'h20;
        rd_i = 5'd12; wb_reg_wr_i = 1;
        issue("sub", 0, 1);
        clear_in(); r1_i = 5'd13; d1_i = 32'h8000_0000; imm_i = 32'h404; ex_imm_sel_i = 1;
        ex_f3_i = 3'd5; ex_f7_i = 7'h20; rd_i = 5'd13; wb_reg_wr_i = 1;
        issue("srai", 0, 1);
        chk("sub_value", 76'(exmem_alu_o), 76'hFFFF_FFFE);
        clear_in();
        issue("idle4", 0, 1);
        chk("sra_value", 76'(exmem_alu_o), 76'hF800_0000);

        // Store held in EX/MEM by stall_i[3]
        clear_in(); r1_i = 5'd14; d1_i = 32'h100; r2_i = 5'd15; d2_i = 32'hDEAD; imm_i = 32'd8;
        ex_imm_sel_i = 1; mem_wr_i = 1; mem_f3_i = 3'd2;
        issue("store", 0, 1);
        saved_exp = last_exp;
        clear_in();
        issue("idle5", 0, 0);
        stall_i = 5'b01000;
        q_exp.push_back(saved_exp); q_due.push_back(cyc + 1); q_tag.push_back("stall3_hold1");
        q_exp.push_back(saved_exp); q_due.push_back(cyc + 2); q_tag.push_back("stall3_hold2");
        tick();
        tick();
        chk("stall3_wdata", 76'(exmem_wdata_o), 76'hDEAD);
        stall_i = '0;
        q_exp.push_back('0); q_due.push_back(cyc + 1); q_tag.push_back("stall3_release");
        tick();
        prev_wre = 1'b0;

        // stall_i[2] alone: bubble into EX/MEM, instruction re-executes
        clear_in(); imm_i = 32'h33; ex_imm_sel_i = 1; rd_i = 5'd14; wb_reg_wr_i = 1;
        issue("addi_x14", 0, 0);
        saved_exp = last_exp;
        clear_in();
        stall_i = 5'b00100;
        q_exp.push_back('0); q_due.push_back(cyc + 1); q_tag.push_back("stall2_bubble");
        tick();
        stall_i = '0;
        q_exp.push_back(saved_exp); q_due.push_back(cyc + 1); q_tag.push_back("stall2_resume");
        tick();
        prev_wre = 1'b0;

        // Reset mid-operation discards in-flight instructions
        clear_in(); imm_i = 32'h77; ex_imm_sel_i = 1; rd_i = 5'd15; wb_reg_wr_i = 1;
        issue("addi_x15", 0, 0);
        clear_in(); pc_i = 32'h80; ex_jmp_i = 1; ex_pc_sel_i = 1; ex_imm_sel_i = 1; imm_i = 32'h10;
        rd_i = 5'd16; wb_reg_wr_i = 1;
        issue("jal_x16", 0, 0);
        clear_in();
        rst = 1;
        tick();
        rst = 0;
        chk("midreset.exmem", get_obs(), '0);
        chk("midreset.br_en", 76'(br_jmp_en_o), 76'd0);
        chk("midreset.br_addr", 76'(br_addr_o), 76'd0);

        chk("scoreboard_drained", 76'(q_exp.size()), 76'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
